// File: rtl/room_sequencer.sv
// room_sequencer: selects and fades the on-screen room and sequences fade-out/swap/fade-in room transitions
module room_sequencer #(
    parameter int GRID_W     = 3,
    parameter int GRID_H     = 3,
    parameter int START_ROOM = 4,
    parameter int EDGE_N     = 40,
    parameter int EDGE_S     = 440,
    parameter int EDGE_W     = 40,
    parameter int EDGE_E     = 600,
    parameter int SPAWN_N    = 48,
    parameter int SPAWN_S    = 400,
    parameter int SPAWN_W    = 48,
    parameter int SPAWN_E    = 592
) (
    input  logic                                 clk_vga,
    input  logic                                 rst,
    input  logic [9:0]                           CurrentX,
    input  logic [8:0]                           CurrentY,
    input  logic [9:0]                           PlayerX,
    input  logic [8:0]                           PlayerY,
    input  logic [4*GRID_W*GRID_H-1:0]           exits,
    input  logic [8*GRID_W*GRID_H-1:0]           room_data,
    output logic [7:0]                           mapData,
    output logic [$clog2(GRID_W*GRID_H)-1:0]     room_idx,
    output logic                                 busy,
    output logic                                 teleport,
    output logic [9:0]                           tp_x,
    output logic [8:0]                           tp_y
);
    localparam int NR = GRID_W * GRID_H;
    localparam int IW = $clog2(NR);
    localparam logic [8:0] EN = 9'(EDGE_N);
    localparam logic [8:0] ES = 9'(EDGE_S);
    localparam logic [9:0] EW = 10'(EDGE_W);
    localparam logic [9:0] EE = 10'(EDGE_E);
    localparam logic [8:0] SN = 9'(SPAWN_N);
    localparam logic [8:0] SS = 9'(SPAWN_S);
    localparam logic [9:0] SW = 10'(SPAWN_W);
    localparam logic [9:0] SE = 10'(SPAWN_E);
    localparam logic [IW-1:0] ROW_STEP = IW'(GRID_W);
    localparam logic [IW-1:0] START = IW'(START_ROOM);

    typedef enum logic [1:0] {PLAY, FADE_OUT, SWAP, FADE_IN} state_t;
    typedef enum logic [2:0] {D_NONE, D_N, D_S, D_W, D_E} dir_t;

    state_t state, state_n;
    dir_t dir, dir_n, req;
    logic [2:0] level, level_n;
    logic origin_q, origin_d, frame_start;
    logic [3:0] exit_tab [NR];
    logic [7:0] pix_tab [NR];
    logic [3:0] open_ex;
    logic [7:0] pix, faded;
    logic [IW-1:0] next_room;
    logic [9:0] spawn_x;
    logic [8:0] spawn_y;

    // Per-room exit bits are masked by the room's fixed grid position, so no runtime divide is needed
    for (genvar r = 0; r < NR; r++) begin : g_room
        localparam int ROW = r / GRID_W;
        localparam int COL = r % GRID_W;
        assign exit_tab[r] = exits[4*r +: 4] & {COL < GRID_W-1, COL > 0, ROW < GRID_H-1, ROW > 0};
        assign pix_tab[r] = room_data[8*r +: 8];
    end

    assign open_ex = exit_tab[room_idx];
    assign pix = pix_tab[room_idx];
    assign frame_start = origin_q & ~origin_d;
    assign req = (open_ex[0] && PlayerY < EN) ? D_N :
                 (open_ex[1] && PlayerY >= ES) ? D_S :
                 (open_ex[2] && PlayerX < EW) ? D_W :
                 (open_ex[3] && PlayerX >= EE) ? D_E : D_NONE;
    assign next_room = dir == D_N ? room_idx - ROW_STEP :
                       dir == D_S ? room_idx + ROW_STEP :
                       dir == D_W ? room_idx - IW'(1) :
                       dir == D_E ? room_idx + IW'(1) : room_idx;
    assign spawn_x = dir == D_W ? SE : dir == D_E ? SW : PlayerX;
    assign spawn_y = dir == D_N ? SS : dir == D_S ? SN : PlayerY;
    assign faded = level[2] ? 8'h00 : {pix[7:5] >> level[1:0], pix[4:2] >> level[1:0], pix[1:0] >> level[1:0]};

    // Registered origin compare plus its delayed copy give one frame_start pulse per frame
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            origin_q <= 1'b0;
            origin_d <= 1'b0;
        end else begin
            origin_q <= (CurrentX == 10'd0) && (CurrentY == 9'd0);
            origin_d <= origin_q;
        end
    end

    // Transition state register
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state <= PLAY;
            level <= 3'd0;
            dir   <= D_NONE;
        end else begin
            state <= state_n;
            level <= level_n;
            dir   <= dir_n;
        end
    end

    // Frame-paced transition sequencing; only SWAP advances without a frame_start
    always_comb begin
        state_n = state;
        level_n = level;
        dir_n   = dir;
        case (state)
            PLAY: if (frame_start && req != D_NONE) begin
                state_n = FADE_OUT;
                level_n = 3'd1;
                dir_n   = req;
            end
            FADE_OUT: if (frame_start) begin
                level_n = level + 3'd1;
                state_n = level == 3'd3 ? SWAP : FADE_OUT;
            end
            SWAP: state_n = FADE_IN;
            FADE_IN: if (frame_start) begin
                level_n = level - 3'd1;
                state_n = level == 3'd1 ? PLAY : FADE_IN;
                dir_n   = level == 3'd1 ? D_NONE : dir;
            end
            default: state_n = PLAY;
        endcase
    end

    // Room swap, teleport pulse, busy flag and the faded pixel output
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            room_idx <= START;
            teleport <= 1'b0;
            tp_x     <= 10'd0;
            tp_y     <= 9'd0;
            busy     <= 1'b0;
            mapData  <= 8'h00;
        end else begin
            busy     <= state != PLAY;
            teleport <= state == SWAP;
            room_idx <= state == SWAP ? next_room : room_idx;
            tp_x     <= state == SWAP ? spawn_x : tp_x;
            tp_y     <= state == SWAP ? spawn_y : tp_y;
            mapData  <= faded;
        end
    end
endmodule

// File: doc/room_sequencer.md
Name: room_sequencer

Overview:
- Owns "which room is on screen" for the adventure map.
- Selects one room renderer's 8-bit RRRGGGBB pixel stream out of a grid of rooms.
- Watches the player position for exits and runs a frame-synchronised fade-out/swap/fade-in transition when the player leaves a room.
- Sits between the per-room renderers and the VGA colour output. It also drives a teleport pulse back to the player-movement logic.

Parameters:
- GRID_W, 3: rooms per row.
- GRID_H, 3: rooms per column. NUM_ROOMS = GRID_W*GRID_H.
- START_ROOM, 4: room index after reset. Index = row*GRID_W + col, with row 0 at the top.
- EDGE_N, 40: PlayerY < EDGE_N counts as a north-edge hit.
- EDGE_S, 440: PlayerY >= EDGE_S counts as a south-edge hit.
- EDGE_W, 40: PlayerX < EDGE_W counts as a west-edge hit.
- EDGE_E, 600: PlayerX >= EDGE_E counts as an east-edge hit.
- SPAWN_N, 48: Y coordinate after entering through a south move.
- SPAWN_S, 400: Y coordinate after entering through a north move.
- SPAWN_W, 48: X coordinate after entering through an east move.
- SPAWN_E, 592: X coordinate after entering through a west move.

Ports:
- clk_vga, in, 1: pixel clock. This is the only clock.
- rst, in, 1: asynchronous, active-high reset.
- CurrentX, in, 10: scan X position.
- CurrentY, in, 9: scan Y position.
- PlayerX, in, 10: player X position.
- PlayerY, in, 9: player Y position.
- exits, in, 4*NUM_ROOMS: per-room exit-open bits. Room r uses bits [4r+3:4r] = {E,W,S,N}.
- room_data, in, 8*NUM_ROOMS: pixel colour from each room renderer. Room r uses bits [8r+7:8r].
- mapData, out, 8: faded, selected pixel colour. Registered.
- room_idx, out, ceil(log2 NUM_ROOMS): current room index. Registered.
- busy, out, 1: high in every state except PLAY. Player movement freezes while busy is high.
- teleport, out, 1: one-cycle pulse asking the movement logic to load tp_x/tp_y.
- tp_x, out, 10: new player X, valid while teleport is high.
- tp_y, out, 9: new player Y, valid while teleport is high.

Behaviour:
- Reset values (asynchronous):
  - state = PLAY, level = 0, room_idx = START_ROOM, mapData = 0.
  - teleport = 0, tp_x = 0, tp_y = 0, busy = 0, dir = none.
  - Asserting rst mid-fade aborts the transition immediately. No teleport pulse is issued.
- frame_start: the registered compare (CurrentX==0 && CurrentY==0) is edge-detected. This gives exactly one pulse per frame, one cycle after the scan reaches the origin.
- Exit request, evaluated combinationally from PlayerX/PlayerY and exits[room_idx]:
  - N requires PlayerY < EDGE_N, N bit set and row > 0.
  - S requires PlayerY >= EDGE_S, S bit set and row < GRID_H-1.
  - W requires PlayerX < EDGE_W, W bit set and col > 0.
  - E requires PlayerX >= EDGE_E, E bit set and col < GRID_W-1.
  - Priority is N > S > W > E.
  - At a grid edge the exit is blocked even if its exit bit is set.
- FSM. State, level and dir change only on frame_start, except the one-cycle SWAP:
  - PLAY: on frame_start with a valid request, latch dir, set level = 1 and go to FADE_OUT. A request that is not present on frame_start is ignored.
  - FADE_OUT: on each frame_start, level increments. When level reaches 4, go to SWAP.
  - SWAP (exactly one cycle):
    - Update room_idx: N = -GRID_W, S = +GRID_W, W = -1, E = +1.
    - Pulse teleport and drive tp_x/tp_y.
    - N: tp_y = SPAWN_S, tp_x = PlayerX. S: tp_y = SPAWN_N, tp_x = PlayerX.
    - W: tp_x = SPAWN_E, tp_y = PlayerY. E: tp_x = SPAWN_W, tp_y = PlayerY.
    - Then go to FADE_IN.
  - FADE_IN: on each frame_start, level decrements. When level reaches 0, go to PLAY.
  - busy is high one cycle after leaving PLAY and low one cycle after re-entering it.
  - Exit requests are ignored outside PLAY, including during the first frame of PLAY after FADE_IN if no frame_start has occurred yet.
- Pixel path:
  - Each cycle, mapData <= fade(room_data[8*room_idx +: 8], level). The path has 1-cycle latency relative to room_data.
  - fade with level L in 0..3: R[7:5], G[4:2] and B[1:0] are each logically right-shifted by L, and the results are packed back in place.
  - fade with L = 4: output 8'h00.
  - room_idx changes only in SWAP. Every pixel from level 4 onward is black, so the swap is never visible.
- Arithmetic:
  - row = room_idx / GRID_W and col = room_idx % GRID_W. These are computed as constants per index with a generate case, with no runtime divider.
  - room_idx never leaves 0..NUM_ROOMS-1.

Test Plan:
- Reset check: hold rst high, then release, with room_data for room 4 = 8'hB6 → room_idx = 4, busy = 0, teleport = 0, and mapData = 8'hB6 one cycle after each room_data sample.
- North exit: room 4, exits[19:16] = 4'b0001, PlayerY = 20, PlayerX = 300 → busy rises after frame_start. mapData for input 8'hFF reads 8'h6D at level 1, then 8'h24 at level 2, then 8'h00 from level 4. teleport pulses once with tp_y = 400, tp_x = 300. room_idx = 1. Level returns to 0 after 4 more frames.
- Blocked exits: room 1 (top row), N bit set, PlayerY = 10 → stays in PLAY across 5 frames, room_idx = 1, no teleport. Repeat with room 4 and the N bit clear → same result.
- Priority: PlayerY = 10 and PlayerX = 10 with both N and W open in room 4 → room_idx becomes 1, not 3. tp_y = 400, tp_x = 10.
- Mid-fade reset: assert rst at level 2 of FADE_OUT → next cycle state = PLAY, room_idx = START_ROOM, mapData tracks room_data unfaded, and no teleport pulse.
- East then west round trip: room 4 → E to room 5 with tp_x = 48 → W back to room 4 with tp_x = 592. Player movement during busy is ignored.
